// File: rtl/led_breath_if.sv
// led_breath_if: control/status bundle between the switch side and the LED breathing controller.
// The master side drives enable, mode and colour select.
// The slave side (the controller) returns the LED pins and the brightness status.
interface led_breath_if #(
    parameter int unsigned N_CH  = 2,
    parameter int unsigned BRT_W = 5
);
    logic                 en;
    logic [1:0]           mode;
    logic [1:0]           sw;
    logic [3*N_CH-1:0]    led_rgb;
    logic [BRT_W-1:0]     brightness;
    logic                 dir;
    logic                 step_strobe;

    modport master (
        output en,
        output mode,
        output sw,
        input  led_rgb,
        input  brightness,
        input  dir,
        input  step_strobe
    );

    modport slave (
        input  en,
        input  mode,
        input  sw,
        output led_rgb,
        output brightness,
        output dir,
        output step_strobe
    );
endinterface

// File: rtl/led_breath_ctrl.sv
// led_breath_ctrl: multi-channel RGB LED breathing / blink controller.
// A prescaler and a hold counter produce brightness steps.
// An FSM moves the shared brightness level in response to those steps.
// Each channel's 8-bit colour PWM is gated by a brightness PWM.
// Odd channels run in anti-phase to even channels.
module led_breath_ctrl #(
    parameter int unsigned N_CH       = 2,
    parameter int unsigned BRT_W      = 5,
    parameter int unsigned PRESC      = 1000,
    parameter int unsigned HOLD_TICKS = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    led_breath_if.slave bus
);

    localparam int unsigned PW = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam int unsigned HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

    localparam logic [PW-1:0]    PRESC_LAST = PW'(PRESC - 1);
    localparam logic [HW-1:0]    HOLD_LAST  = HW'(HOLD_TICKS - 1);
    localparam logic [BRT_W-1:0] BRT_MAX    = {BRT_W{1'b1}};
    localparam logic [BRT_W-1:0] BRT_ONE    = BRT_W'(1);

    typedef enum logic [2:0] {
        S_OFF,
        S_STATIC,
        S_UP,
        S_DOWN,
        S_BLINK
    } state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic [HW-1:0]       hold_q, hold_d;
    logic [BRT_W-1:0]    brt_q, brt_d;
    logic                dir_q, dir_d;
    logic [7:0]          cpwm_q;
    logic [BRT_W-1:0]    bpwm_q;
    logic [3*N_CH-1:0]   led_q, led_d;

    logic                tick;
    logic                step;
    logic [1:0]          cur_mode;
    logic                mode_change;
    logic [7:0]          comp_r, comp_g, comp_b;
    logic [2:0]          colour;
    logic [BRT_W-1:0]    brt_k;
    logic                on_k;

    // Tick and step pulses only exist while enabled, so a frozen block never steps
    assign tick = bus.en && (presc_q == PRESC_LAST);
    assign step = tick && (hold_q == HOLD_LAST);

    // Mode group the FSM is currently serving; both breathe states share one group
    always_comb begin
        cur_mode = 2'b00;
        unique case (state_q)
            S_OFF:         cur_mode = 2'b00;
            S_STATIC:      cur_mode = 2'b01;
            S_UP, S_DOWN:  cur_mode = 2'b10;
            S_BLINK:       cur_mode = 2'b11;
            default:       cur_mode = 2'b00;
        endcase
    end

    assign mode_change = (bus.mode != cur_mode);

    // Next-state: timing counters, FSM, brightness and direction
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        hold_d  = hold_q;
        brt_d   = brt_q;
        dir_d   = dir_q;

        if (bus.en) begin
            if (tick) begin
                presc_d = '0;
                hold_d  = (hold_q == HOLD_LAST) ? '0 : hold_q + HW'(1);
            end else begin
                presc_d = presc_q + PW'(1);
            end

            if (mode_change) begin
                // Entering a mode restarts its timing from a clean phase
                presc_d = '0;
                hold_d  = '0;
                dir_d   = 1'b0;
                unique case (bus.mode)
                    2'b00: begin
                        state_d = S_OFF;
                        brt_d   = '0;
                    end
                    2'b01: begin
                        state_d = S_STATIC;
                        brt_d   = BRT_MAX;
                    end
                    2'b10: begin
                        state_d = S_UP;
                        brt_d   = '0;
                    end
                    2'b11: begin
                        state_d = S_BLINK;
                        brt_d   = BRT_MAX;
                    end
                    default: begin
                        state_d = S_OFF;
                        brt_d   = '0;
                    end
                endcase
            end else if (step) begin
                unique case (state_q)
                    S_UP: begin
                        // Turn around at the top on the same edge: no dwell at MAX
                        if (brt_q == BRT_MAX) begin
                            brt_d   = BRT_MAX - BRT_ONE;
                            state_d = S_DOWN;
                            dir_d   = 1'b1;
                        end else begin
                            brt_d = brt_q + BRT_ONE;
                        end
                    end
                    S_DOWN: begin
                        if (brt_q == '0) begin
                            brt_d   = BRT_ONE;
                            state_d = S_UP;
                            dir_d   = 1'b0;
                        end else begin
                            brt_d = brt_q - BRT_ONE;
                        end
                    end
                    S_BLINK: begin
                        brt_d = (brt_q == BRT_MAX) ? '0 : BRT_MAX;
                    end
                    default: begin
                        brt_d = brt_q;
                    end
                endcase
            end
        end
    end

    // State, timing and brightness registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_OFF;
            presc_q <= '0;
            hold_q  <= '0;
            brt_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            hold_q  <= hold_d;
            brt_q   <= brt_d;
            dir_q   <= dir_d;
        end
    end

    // Free-running PWM counters; they freeze with the rest of the block when disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpwm_q <= '0;
            bpwm_q <= '0;
        end else if (bus.en) begin
            cpwm_q <= cpwm_q + 8'd1;
            bpwm_q <= bpwm_q + BRT_ONE;
        end
    end

    // Colour table selected by the switches
    always_comb begin
        comp_r = 8'h00;
        comp_g = 8'h00;
        comp_b = 8'h00;
        unique case (bus.sw)
            2'b00: begin comp_r = 8'h7F; comp_g = 8'h1F; comp_b = 8'hFF; end
            2'b01: begin comp_r = 8'h00; comp_g = 8'hFF; comp_b = 8'hFF; end
            2'b10: begin comp_r = 8'hFF; comp_g = 8'hFF; comp_b = 8'h00; end
            2'b11: begin comp_r = 8'hFF; comp_g = 8'h00; comp_b = 8'hFF; end
            default: begin comp_r = 8'h00; comp_g = 8'h00; comp_b = 8'h00; end
        endcase
    end

    // Strict compare: FF yields 255/256 duty and 00 is always off
    assign colour = {(cpwm_q < comp_r), (cpwm_q < comp_g), (cpwm_q < comp_b)};

    // Per-channel brightness gating; odd channels use the complementary level
    always_comb begin
        led_d = '0;
        brt_k = '0;
        on_k  = 1'b0;
        for (int k = 0; k < int'(N_CH); k++) begin
            brt_k = ((k % 2) == 0) ? brt_q : (BRT_MAX - brt_q);
            on_k  = (state_q != S_OFF) && (bpwm_q < brt_k);
            led_d[3*k +: 3] = colour & {3{on_k}} & {3{bus.en}};
        end
    end

    // Registered LED pins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q <= '0;
        end else begin
            led_q <= led_d;
        end
    end

    assign bus.led_rgb     = led_q;
    assign bus.brightness  = brt_q;
    assign bus.dir         = dir_q;
    assign bus.step_strobe = step;

endmodule

// File: tb/tb_led_breath_ctrl.sv
// tb_led_breath_ctrl: directed bench for led_breath_ctrl with a short prescaler and hold count.
// A step lands every PRESC*HOLD_TICKS = 8 clocks.
module tb_led_breath_ctrl;

    localparam int unsigned N_CH       = 2;
    localparam int unsigned BRT_W      = 5;
    localparam int unsigned PRESC      = 2;
    localparam int unsigned HOLD_TICKS = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int checks   = 0;
    int failures = 0;
    int cnt[6];

    led_breath_if #(.N_CH(N_CH), .BRT_W(BRT_W)) bus ();

    led_breath_ctrl #(
        .N_CH       (N_CH),
        .BRT_W      (BRT_W),
        .PRESC      (PRESC),
        .HOLD_TICKS (HOLD_TICKS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Wait for a step strobe (bounded), then consume the step edge
    task automatic step_wait(output int n);
        n = 0;
        while (bus.step_strobe !== 1'b1 && n < 64) begin
            cycle();
            n++;
        end
        if (bus.step_strobe !== 1'b1)
            check_eq("strobe_timeout", 32'(bus.step_strobe), 32'd1);
        cycle();
    endtask

    // Steps from an aligned phase must arrive every 8 clocks
    task automatic run_steps(input int count);
        int n;
        for (int i = 0; i < count; i++) begin
            step_wait(n);
            check_eq("step_period", n + 1, 32'd8);
        end
    endtask

    // Count high cycles of each LED bit over one full colour-PWM period
    task automatic count_duty();
        for (int b = 0; b < 6; b++) cnt[b] = 0;
        for (int i = 0; i < 256; i++) begin
            cycle();
            for (int b = 0; b < 6; b++) cnt[b] += int'(bus.led_rgb[b]);
        end
    endtask

    initial begin
        int          n;
        logic [5:0]  led_or;
        logic        strobe_or;
        logic        brt_moved;

        bus.en   = 1'b0;
        bus.mode = 2'b00;
        bus.sw   = 2'b00;
        #1 rst_n = 1'b0;
        #1;
        check_eq("rst_brightness", 32'(bus.brightness), 32'd0);
        check_eq("rst_dir", 32'(bus.dir), 32'd0);
        check_eq("rst_strobe", 32'(bus.step_strobe), 32'd0);
        check_eq("rst_led", 32'(bus.led_rgb), 32'd0);
        cycle();
        cycle();

        // Breathe from reset: full ramp up, top and bottom turnarounds
        bus.en   = 1'b1;
        bus.mode = 2'b10;
        rst_n    = 1'b1;
        cycle();
        check_eq("brth_entry_brt", 32'(bus.brightness), 32'd0);
        check_eq("brth_entry_dir", 32'(bus.dir), 32'd0);
        run_steps(1);
        check_eq("brth_first_step", 32'(bus.brightness), 32'd1);
        check_eq("strobe_one_cycle", 32'(bus.step_strobe), 32'd0);
        run_steps(30);
        check_eq("brth_top", 32'(bus.brightness), 32'd31);
        check_eq("brth_top_dir", 32'(bus.dir), 32'd0);
        run_steps(1);
        check_eq("brth_turn_down", 32'(bus.brightness), 32'd30);
        check_eq("brth_turn_down_dir", 32'(bus.dir), 32'd1);
        run_steps(30);
        check_eq("brth_bottom", 32'(bus.brightness), 32'd0);
        check_eq("brth_bottom_dir", 32'(bus.dir), 32'd1);
        run_steps(1);
        check_eq("brth_turn_up", 32'(bus.brightness), 32'd1);
        check_eq("brth_turn_up_dir", 32'(bus.dir), 32'd0);

        // Freeze at 12 mid-phase (3 clocks into the step), then resume
        run_steps(11);
        check_eq("frz_brt_before", 32'(bus.brightness), 32'd12);
        cycle();
        cycle();
        cycle();
        bus.en    = 1'b0;
        led_or    = '0;
        strobe_or = 1'b0;
        brt_moved = 1'b0;
        for (int i = 0; i < 50; i++) begin
            cycle();
            led_or    |= bus.led_rgb;
            strobe_or |= bus.step_strobe;
            if (bus.brightness !== 5'd12) brt_moved = 1'b1;
        end
        check_eq("frz_led_dark", 32'(led_or), 32'd0);
        check_eq("frz_no_strobe", 32'(strobe_or), 32'd0);
        check_eq("frz_brt_held", 32'(brt_moved), 32'd0);
        bus.en = 1'b1;
        step_wait(n);
        check_eq("frz_resume_phase", n, 32'd4);
        check_eq("frz_resume_brt", 32'(bus.brightness), 32'd13);

        // Asynchronous reset pulse at brightness 20
        run_steps(7);
        check_eq("arst_brt_before", 32'(bus.brightness), 32'd20);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_brt", 32'(bus.brightness), 32'd0);
        check_eq("arst_dir", 32'(bus.dir), 32'd0);
        check_eq("arst_strobe", 32'(bus.step_strobe), 32'd0);
        check_eq("arst_led", 32'(bus.led_rgb), 32'd0);
        cycle();
        rst_n = 1'b1;
        cycle();
        check_eq("arst_restart_brt", 32'(bus.brightness), 32'd0);
        run_steps(1);
        check_eq("arst_restart_step", 32'(bus.brightness), 32'd1);

        // Breathe at 17, mid-phase switch to OFF then back to BREATHE
        run_steps(16);
        check_eq("off_brt_before", 32'(bus.brightness), 32'd17);
        cycle();
        cycle();
        cycle();
        bus.mode = 2'b00;
        cycle();
        check_eq("off_brt", 32'(bus.brightness), 32'd0);
        cycle();
        led_or = '0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            led_or |= bus.led_rgb;
        end
        check_eq("off_all_dark", 32'(led_or), 32'd0);
        bus.mode = 2'b10;
        cycle();
        check_eq("rebrth_brt", 32'(bus.brightness), 32'd0);
        check_eq("rebrth_dir", 32'(bus.dir), 32'd0);
        step_wait(n);
        check_eq("rebrth_hold_cleared", n, 32'd7);
        check_eq("rebrth_step", 32'(bus.brightness), 32'd1);

        // STATIC: duty counts over one colour period (bit order per channel R,G,B = 2,1,0)
        bus.mode = 2'b01;
        bus.sw   = 2'b01;
        cycle();
        check_eq("static_brt", 32'(bus.brightness), 32'd31);
        cycle();
        count_duty();
        check_eq("st01_r0", cnt[2], 32'd0);
        check_eq("st01_g0", cnt[1], 32'd248);
        check_eq("st01_b0", cnt[0], 32'd248);
        check_eq("st01_ch1", cnt[3] + cnt[4] + cnt[5], 32'd0);
        bus.sw = 2'b10;
        cycle();
        count_duty();
        check_eq("st10_r0", cnt[2], 32'd248);
        check_eq("st10_b0", cnt[0], 32'd0);
        bus.sw = 2'b00;
        cycle();
        count_duty();
        check_eq("st00_r0", cnt[2], 32'd124);
        check_eq("st00_g0", cnt[1], 32'd31);
        check_eq("st00_b0", cnt[0], 32'd248);

        // BLINK: alternate 31/0, odd channel complementary
        bus.mode = 2'b11;
        cycle();
        check_eq("blink_entry_brt", 32'(bus.brightness), 32'd31);
        step_wait(n);
        check_eq("blink_period", n + 1, 32'd8);
        check_eq("blink_low", 32'(bus.brightness), 32'd0);
        led_or = '0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            led_or |= bus.led_rgb;
        end
        check_eq("blink_low_ch0_dark", 32'(led_or[2:0]), 32'd0);
        check_eq("blink_low_ch1_blue", 32'(led_or[3]), 32'd1);
        step_wait(n);
        check_eq("blink_high", 32'(bus.brightness), 32'd31);
        led_or = '0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            led_or |= bus.led_rgb;
        end
        check_eq("blink_high_ch1_dark", 32'(led_or[5:3]), 32'd0);
        check_eq("blink_high_ch0_blue", 32'(led_or[0]), 32'd1);
        step_wait(n);
        check_eq("blink_low_again", 32'(bus.brightness), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
